data_mem_access_unit: RTL and testbench

- MEM-stage data memory with variable latency.
- Accepts a load/store request from EX/MEM, performs a byte-, half- or word-sized access into an internal word array, and stalls the pipeline until done.
- Produces the 32-bit read data consumed by the MEM/WB pipeline register.
- Flags misaligned accesses instead of performing them.

---
 rtl/data_mem_access_unit_if.sv | 26 ++
 rtl/data_mem_access_unit.sv | 190 +++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_access_unit_if.sv
// Request/response bundle between the EX/MEM pipeline side and the MEM-stage
// data memory access unit.
interface data_mem_access_unit_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        ready;
  logic        misaligned;

  // Pipeline side: issues requests, consumes results and stall.
  modport master (
    output mem_read, mem_write, size, load_unsigned, address, write_data,
    input  read_data, stall, ready, misaligned
  );

  // Memory unit side.
  modport slave (
    input  mem_read, mem_write, size, load_unsigned, address, write_data,
    output read_data, stall, ready, misaligned
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// MEM-stage data memory with a programmable number of wait states.
// Byte/half/word loads and stores into an internal little-endian word array;
// misaligned requests are flagged and skipped. The pipeline is stalled from
// the cycle a request is seen until the cycle before the one-cycle DONE pulse.
module data_mem_access_unit #(
  parameter int ADDR_WORD_BITS = 8,
  parameter int WAIT_STATES    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_access_unit_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WORD_BITS;
  localparam int AW    = ADDR_WORD_BITS + 2;  // byte-address bits actually used

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_WRD2 = 2'b11
  } size_t;

  typedef struct packed {
    logic          op_write;
    size_t         size;
    logic          load_unsigned;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } req_t;

  logic [31:0] mem [DEPTH];

  state_t      state_q,      state_d;
  logic [3:0]  count_q,      count_d;
  logic [31:0] read_data_q,  read_data_d;
  logic        ready_q,      ready_d;
  logic        misaligned_q, misaligned_d;
  req_t        req_q,        req_d;

  logic        req;
  logic        req_misaligned;
  logic        mem_we;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes;
  logic [31:0] rd_word;
  logic [31:0] load_value;
  logic [ADDR_WORD_BITS-1:0] word_idx;

  // Upper address bits are ignored on purpose: accesses wrap modulo memory size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.address[31:AW];

  assign req = bus.mem_read | bus.mem_write;

  // Alignment check on the incoming request (size 11 behaves as a word).
  always_comb begin
    unique case (size_t'(bus.size))
      SZ_BYTE:          req_misaligned = 1'b0;
      SZ_HALF:          req_misaligned = bus.address[0];
      SZ_WORD, SZ_WRD2: req_misaligned = |bus.address[1:0];
      default:          req_misaligned = 1'b0;
    endcase
  end

  assign word_idx = req_q.addr[AW-1:2];
  assign rd_word  = mem[word_idx];

  // Lane selection and sign/zero extension of the load result.
  always_comb begin
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = rd_word >> {req_q.addr[1:0], 3'b000};
    half    = req_q.addr[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (req_q.size)
      SZ_BYTE: load_value = req_q.load_unsigned ? {24'h0, shifted[7:0]}
                                                : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_value = req_q.load_unsigned ? {16'h0, half}
                                                : {{16{half[15]}}, half};
      default: load_value = rd_word;
    endcase
  end

  // Byte enables and replicated store data for the addressed lanes.
  always_comb begin
    unique case (req_q.size)
      SZ_BYTE: begin
        byte_en  = 4'b0001 << req_q.addr[1:0];
        wr_lanes = {4{req_q.wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en  = req_q.addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{req_q.wdata[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = req_q.wdata;
      end
    endcase
  end

  // Next-state and output logic of the IDLE/BUSY/DONE controller.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    count_d      = count_q;
    read_data_d  = read_data_q;
    ready_d      = 1'b0;
    misaligned_d = 1'b0;
    req_d        = req_q;
    mem_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          req_d.op_write      = bus.mem_write;
          req_d.size          = size_t'(bus.size);
          req_d.load_unsigned = bus.load_unsigned;
          req_d.addr          = bus.address[AW-1:0];
          req_d.wdata         = bus.write_data;
          if (req_misaligned) begin
            state_d      = DONE;
            ready_d      = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            count_d = 4'(WAIT_STATES);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          state_d = DONE;
          ready_d = 1'b1;
          if (req_q.op_write) mem_we      = 1'b1;
          else                read_data_d = load_value;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= 4'd0;
      read_data_q  <= 32'h0;
      ready_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      read_data_q  <= read_data_d;
      ready_q      <= ready_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Latched request fields; only meaningful after IDLE accepts a request.
  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  // Storage array; a store commits on the final BUSY edge unless reset aborts it.
  always_ff @(posedge clk) begin
    // NOTE: the memory array is deliberately not reset; contents survive reset.
    if (mem_we && !reset) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[word_idx][8*k +: 8] <= wr_lanes[8*k +: 8];
      end
    end
  end

  assign bus.stall      = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign bus.ready      = ready_q;
  assign bus.misaligned = misaligned_q;
  assign bus.read_data  = read_data_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed table-driven bench for data_mem_access_unit (WAIT_STATES=2,
// 256-word memory), plus hand-written back-to-back and reset-abort sequences.
module tb_data_mem_access_unit;

  localparam int WS  = 2;
  localparam int AWB = 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  data_mem_access_unit_if bus();

  data_mem_access_unit #(.ADDR_WORD_BITS(AWB), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        chain;   // next vector is issued in this vector's DONE cycle
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic rd, logic wr, logic [1:0] size, logic uns,
                               logic [31:0] addr, logic [31:0] wdata,
                               logic [31:0] exp_rd, logic exp_mis, logic chain,
                               string name);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.exp_rd = exp_rd; v.exp_mis = exp_mis; v.chain = chain;
    v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.size          = 2'b00;
    bus.load_unsigned = 1'b0;
    bus.address       = 32'h0;
    bus.write_data    = 32'h0;
  endtask

  // Issue one request, hold it while stalled, and check latency, stall length
  // and the DONE-cycle outputs. Called about 1 time unit after a rising edge.
  task automatic do_req(input vec_t v, input bit b2b);
    int idx;
    int stall_cnt;
    int exp_lat;
    bus.mem_read      = v.rd;
    bus.mem_write     = v.wr;
    bus.size          = v.size;
    bus.load_unsigned = v.uns;
    bus.address       = v.addr;
    bus.write_data    = v.wdata;
    if (b2b) begin
      @(posedge clk); #1;
    end else begin
      #1;
    end
    exp_lat   = v.exp_mis ? 1 : WS + 2;
    stall_cnt = 0;
    idx       = 0;
    check($sformatf("%s.ready_t0", v.name), {31'h0, bus.ready}, 32'h0);
    if (bus.stall) stall_cnt++;
    while (idx < 40) begin
      @(posedge clk); #1;
      idx++;
      if (bus.ready) break;
      if (bus.stall) stall_cnt++;
    end
    check($sformatf("%s.latency", v.name), idx, exp_lat);
    check($sformatf("%s.stall_cycles", v.name), stall_cnt, exp_lat);
    check($sformatf("%s.stall_done", v.name), {31'h0, bus.stall}, 32'h0);
    check($sformatf("%s.misaligned", v.name), {31'h0, bus.misaligned}, {31'h0, v.exp_mis});
    check($sformatf("%s.read_data", v.name), bus.read_data, v.exp_rd);
    if (!v.chain) begin
      drive_idle();
      @(posedge clk); #1;
      check($sformatf("%s.ready_drop", v.name), {31'h0, bus.ready}, 32'h0);
      check($sformatf("%s.idle_stall", v.name), {31'h0, bus.stall}, 32'h0);
    end
  endtask

  initial begin
    bit b2b;
    total = 0;
    bad   = 0;
    drive_idle();
    reset = 1'b1;

    //           rd wr sz  u  addr          wdata         exp_rd        mis ch name
    vecs.push_back(mkv(0, 1, 2, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0, 0, "st_w_10"));
    vecs.push_back(mkv(1, 0, 2, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 0, "ld_w_10"));
    vecs.push_back(mkv(0, 1, 2, 0, 32'h0000_0020, 32'h1122_3344, 32'hDEAD_BEEF, 0, 0, "st_w_20"));
    vecs.push_back(mkv(0, 1, 0, 0, 32'h0000_0021, 32'hFFFF_FF80, 32'hDEAD_BEEF, 0, 1, "st_b_21"));
    vecs.push_back(mkv(1, 0, 2, 0, 32'h0000_0020, 32'h0,         32'h1122_8044, 0, 0, "ld_w_20_b2b"));
    vecs.push_back(mkv(1, 0, 0, 0, 32'h0000_0021, 32'h0,         32'hFFFF_FF80, 0, 0, "ld_b_s_21"));
    vecs.push_back(mkv(1, 0, 0, 1, 32'h0000_0021, 32'h0,         32'h0000_0080, 0, 0, "ld_b_u_21"));
    vecs.push_back(mkv(1, 0, 1, 0, 32'h0000_0022, 32'h0,         32'h0000_1122, 0, 0, "ld_h_s_22"));
    vecs.push_back(mkv(0, 1, 1, 0, 32'h0000_0022, 32'h1234_ABCD, 32'h0000_1122, 0, 0, "st_h_22"));
    vecs.push_back(mkv(1, 0, 2, 0, 32'h0000_0020, 32'h0,         32'hABCD_8044, 0, 0, "ld_w_20_b"));
    vecs.push_back(mkv(1, 0, 1, 0, 32'h0000_0022, 32'h0,         32'hFFFF_ABCD, 0, 0, "ld_h_s_22b"));
    vecs.push_back(mkv(1, 0, 1, 1, 32'h0000_0020, 32'h0,         32'h0000_8044, 0, 0, "ld_h_u_20"));
    vecs.push_back(mkv(1, 0, 2, 0, 32'h0000_0013, 32'h0,         32'h0000_8044, 1, 0, "mis_ld_w_13"));
    vecs.push_back(mkv(1, 0, 1, 0, 32'h0000_0005, 32'h0,         32'h0000_8044, 1, 0, "mis_ld_h_05"));
    vecs.push_back(mkv(0, 1, 2, 0, 32'h0000_0011, 32'h0BAD_0BAD, 32'h0000_8044, 1, 0, "mis_st_w_11"));
    vecs.push_back(mkv(0, 1, 0, 0, 32'h0000_0013, 32'h0000_0077, 32'h0000_8044, 0, 1, "st_b_13"));
    vecs.push_back(mkv(1, 0, 2, 0, 32'h0000_0010, 32'h0,         32'h77AD_BEEF, 0, 0, "ld_w_10_b2b"));
    vecs.push_back(mkv(0, 1, 2, 0, 32'h0000_0400, 32'h1234_5678, 32'h77AD_BEEF, 0, 0, "st_w_400"));
    vecs.push_back(mkv(1, 0, 2, 0, 32'h0000_0000, 32'h0,         32'h1234_5678, 0, 0, "ld_w_000_wrap"));
    vecs.push_back(mkv(1, 1, 2, 0, 32'h0000_0040, 32'hCAFE_F00D, 32'h1234_5678, 0, 0, "rd_wr_both"));
    vecs.push_back(mkv(1, 0, 2, 0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 0, 0, "ld_w_40"));
    vecs.push_back(mkv(1, 0, 3, 0, 32'h0000_0010, 32'h0,         32'h77AD_BEEF, 0, 0, "ld_sz3_10"));
    vecs.push_back(mkv(1, 0, 0, 0, 32'h0000_0043, 32'h0,         32'hFFFF_FFCA, 0, 0, "ld_b_s_43"));
    vecs.push_back(mkv(1, 0, 0, 1, 32'h0000_0042, 32'h0,         32'h0000_00FE, 0, 0, "ld_b_u_42"));
    vecs.push_back(mkv(1, 0, 1, 0, 32'h0000_0042, 32'h0,         32'hFFFF_CAFE, 0, 0, "ld_h_s_42"));
    vecs.push_back(mkv(1, 0, 3, 0, 32'h0000_0042, 32'h0,         32'hFFFF_CAFE, 1, 0, "mis_sz3_42"));
    vecs.push_back(mkv(0, 1, 2, 0, 32'h0000_0030, 32'hA5A5_A5A5, 32'hFFFF_CAFE, 0, 0, "st_w_30"));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst.read_data",  bus.read_data, 32'h0);
    check("rst.ready",      {31'h0, bus.ready}, 32'h0);
    check("rst.misaligned", {31'h0, bus.misaligned}, 32'h0);
    check("rst.stall",      {31'h0, bus.stall}, 32'h0);
    @(posedge clk); #1;

    // Table-driven requests.
    b2b = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i], b2b);
      b2b = vecs[i].chain;
    end

    // Reset during BUSY of a store aborts it before the commit edge.
    bus.mem_write  = 1'b1;
    bus.size       = 2'b10;
    bus.address    = 32'h0000_0030;
    bus.write_data = 32'h0000_0055;
    #1;
    check("abort.stall_t0", {31'h0, bus.stall}, 32'h1);
    @(posedge clk); #1;   // BUSY, count 2
    @(posedge clk); #1;   // BUSY, count 1
    check("abort.stall_busy", {31'h0, bus.stall}, 32'h1);
    reset = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort.read_data", bus.read_data, 32'h0);
    check("abort.ready",     {31'h0, bus.ready}, 32'h0);
    check("abort.stall",     {31'h0, bus.stall}, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("abort.no_done", {31'h0, bus.ready}, 32'h0);
    do_req(mkv(1, 0, 2, 0, 32'h0000_0030, 32'h0, 32'hA5A5_A5A5, 0, 0, "ld_w_30_after_abort"), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
